hazard_stall_unit: RTL and testbench

- Stall and freeze generator for the 5-stage pipeline; the stall-side counterpart of the forwarding unit.
- Forwarding routes results that already exist in EX/MEM or MEM/WB. This block holds the front end when a result does not exist yet:
  - load-use hazard: one bubble into ID/EX;
  - multi-cycle data-memory access: full pipeline freeze until the memory acknowledges.
- Sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM/WB register enables.

---
 rtl/hazard_stall_unit.sv | 198 +++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Stall and freeze generator for the 5-stage pipeline. It sits beside the ID
//   stage and covers the cases forwarding cannot: results that do not exist yet.
//     - load-use hazard      : one bubble into ID/EX, PC and IF/ID held
//     - multi-cycle data mem : whole pipeline frozen until mem_ack_i, bounded by
//                              TIMEOUT_CYCLES, after which mem_err_o latches high
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | normal flow; may insert a load-use bubble or start a freeze
//   MEM_WAIT | data-memory access outstanding; everything frozen
//
// Parameters
//   TIMEOUT_CYCLES  max frozen cycles for one access before forced release (>= 2)
//   CNT_W           wait counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   RSaddr_i/RTaddr_i       source registers of the ID instruction
//   RSuse_i/RTuse_i         ID instruction actually reads rs / rt
//   IDEX_MemRead_i          EX instruction is a load
//   IDEX_RTaddr_i           load destination of the EX instruction
//   EXMEM_MemAccess_i       MEM stage accesses data memory this cycle
//   mem_ack_i               data memory completion pulse
//   PCWrite_o, IFIDWrite_o  front-end register enables
//   IDEX_Flush_o            zero the control bits written into ID/EX
//   Freeze_o                hold ID/EX, EX/MEM, MEM/WB
//   mem_err_o               sticky memory-timeout flag
//
// Optional feature, macro HAZARD_PERF_EN
//   Adds saturating 32-bit counters bubble_cnt_o (cycles with IDEX_Flush_o=1)
//   and freeze_cnt_o (cycles with Freeze_o=1). Without the macro neither the
//   ports nor the counter logic exist.

module hazard_stall_unit #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] RSaddr_i,
   input  logic [4:0] RTaddr_i,
   input  logic       RSuse_i,
   input  logic       RTuse_i,
   input  logic       IDEX_MemRead_i,
   input  logic [4:0] IDEX_RTaddr_i,
   input  logic       EXMEM_MemAccess_i,
   input  logic       mem_ack_i,
   output logic       PCWrite_o,
   output logic       IFIDWrite_o,
   output logic       IDEX_Flush_o,
   output logic       Freeze_o,
   output logic       mem_err_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] bubble_cnt_o,
   output logic [31:0] freeze_cnt_o
`endif
);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   generate
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("hazard_stall_unit: TIMEOUT_CYCLES must be >= 2");
      end
      if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
         $error("hazard_stall_unit: CNT_W too narrow for TIMEOUT_CYCLES");
      end
   endgenerate

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;
   logic             err_d;

   logic load_use;
   logic mem_busy;
   logic rs_hit;
   logic rt_hit;

   logic pc_en;
   logic ifid_en;
   logic flush;
   logic freeze;

   // Register 0 is hardwired, so a load "to" r0 never produces a hazard.
   always_comb begin
      rs_hit   = RSuse_i && (IDEX_RTaddr_i == RSaddr_i);
      rt_hit   = RTuse_i && (IDEX_RTaddr_i == RTaddr_i);
      load_use = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) && (rs_hit || rt_hit);
      // An access acknowledged in its first cycle never needs a freeze.
      mem_busy = EXMEM_MemAccess_i && !mem_ack_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      flush   = 1'b0;
      freeze  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Freeze has priority; a coincident load-use bubble is picked up
            // again on the release cycle because inputs are re-evaluated then.
            if (mem_busy) begin
               freeze  = 1'b1;
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               state_d = ST_MEM_WAIT;
               cnt_d   = CNT_ONE;
            end else if (load_use) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               flush   = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            // The ack cycle is still frozen; load_use is irrelevant while ID/EX holds.
            freeze  = 1'b1;
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            if (mem_ack_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced to their idle values while reset is asserted so the
   // pipeline sees a clean "run" indication even with live inputs.
   always_comb begin
      PCWrite_o    = pc_en   || !rst_i;
      IFIDWrite_o  = ifid_en || !rst_i;
      IDEX_Flush_o = flush   && rst_i;
      Freeze_o     = freeze  && rst_i;
      mem_err_o    = err_q;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] freeze_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_q <= '0;
         freeze_cnt_q <= '0;
      end else begin
         if (IDEX_Flush_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
         if (Freeze_o && (freeze_cnt_q != 32'hFFFF_FFFF)) begin
            freeze_cnt_q <= freeze_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      bubble_cnt_o = bubble_cnt_q;
      freeze_cnt_o = freeze_cnt_q;
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

   localparam int T = 8;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [4:0] RSaddr_i = '0;
   logic [4:0] RTaddr_i = '0;
   logic       RSuse_i = 1'b0;
   logic       RTuse_i = 1'b0;
   logic       IDEX_MemRead_i = 1'b0;
   logic [4:0] IDEX_RTaddr_i = '0;
   logic       EXMEM_MemAccess_i = 1'b0;
   logic       mem_ack_i = 1'b0;
   logic       PCWrite_o;
   logic       IFIDWrite_o;
   logic       IDEX_Flush_o;
   logic       Freeze_o;
   logic       mem_err_o;
`ifdef HAZARD_PERF_EN
   logic [31:0] bubble_cnt_o;
   logic [31:0] freeze_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   hazard_stall_unit #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .RSaddr_i          (RSaddr_i),
      .RTaddr_i          (RTaddr_i),
      .RSuse_i           (RSuse_i),
      .RTuse_i           (RTuse_i),
      .IDEX_MemRead_i    (IDEX_MemRead_i),
      .IDEX_RTaddr_i     (IDEX_RTaddr_i),
      .EXMEM_MemAccess_i (EXMEM_MemAccess_i),
      .mem_ack_i         (mem_ack_i),
      .PCWrite_o         (PCWrite_o),
      .IFIDWrite_o       (IFIDWrite_o),
      .IDEX_Flush_o      (IDEX_Flush_o),
      .Freeze_o          (Freeze_o),
      .mem_err_o         (mem_err_o)
`ifdef HAZARD_PERF_EN
      ,
      .bubble_cnt_o      (bubble_cnt_o),
      .freeze_cnt_o      (freeze_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // {PCWrite, IFIDWrite, Flush, Freeze}
   logic [3:0] outs;
   assign outs = {PCWrite_o, IFIDWrite_o, IDEX_Flush_o, Freeze_o};

   localparam logic [3:0] RUN    = 4'b1100;
   localparam logic [3:0] BUBBLE = 4'b0010;
   localparam logic [3:0] FROZEN = 4'b0001;

   // Apply one cycle of inputs at the falling edge, settle, return mid-cycle.
   task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic mr,
                        input logic [4:0] idrt, input logic acc, input logic ack);
      @(negedge clk_i);
      RSaddr_i = rs; RTaddr_i = rt; RSuse_i = rsu; RTuse_i = rtu;
      IDEX_MemRead_i = mr; IDEX_RTaddr_i = idrt;
      EXMEM_MemAccess_i = acc; mem_ack_i = ack;
      #1;
   endtask

   task automatic idle_inputs();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      RSaddr_i = '0; RTaddr_i = '0; RSuse_i = 1'b0; RTuse_i = 1'b0;
      IDEX_MemRead_i = 1'b0; IDEX_RTaddr_i = '0;
      EXMEM_MemAccess_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      #2;
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL reset_outs: got %b want %b", outs, RUN);
      end
      checks++;
      if (mem_err_o !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b want 0", mem_err_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_load_use();
      do_reset();
      drive(5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      checks++;
      if (outs !== BUBBLE) begin
         errors++; $display("FAIL load_use_rs: got %b want %b", outs, BUBBLE);
      end
      idle_inputs();
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL load_use_after: got %b want %b", outs, RUN);
      end
      drive(5'd1, 5'd17, 1'b1, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0);
      checks++;
      if (outs !== BUBBLE) begin
         errors++; $display("FAIL load_use_rt: got %b want %b", outs, BUBBLE);
      end
   endtask

   task automatic test_no_false_stall();
      do_reset();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL no_stall_r0: got %b want %b", outs, RUN);
      end
      drive(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL no_stall_rt_unused: got %b want %b", outs, RUN);
      end
      drive(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL no_stall_not_load: got %b want %b", outs, RUN);
      end
      drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL same_cycle_ack: got %b want %b", outs, RUN);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, (i == 4) ? 1'b1 : 1'b0);
         checks++;
         if (outs !== FROZEN) begin
            errors++; $display("FAIL mem_wait_cycle%0d: got %b want %b", i, outs, FROZEN);
         end
      end
      idle_inputs();
      checks++;
      if (outs !== RUN || mem_err_o !== 1'b0) begin
         errors++; $display("FAIL mem_wait_release: got %b err %b want %b err 0", outs, mem_err_o, RUN);
      end
   endtask

   task automatic test_freeze_vs_load_use();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drive(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1, (i == 3) ? 1'b1 : 1'b0);
         checks++;
         if (outs !== FROZEN) begin
            errors++; $display("FAIL fvl_frozen%0d: got %b want %b", i, outs, FROZEN);
         end
      end
      drive(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
      checks++;
      if (outs !== BUBBLE) begin
         errors++; $display("FAIL fvl_bubble: got %b want %b", outs, BUBBLE);
      end
      idle_inputs();
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL fvl_after: got %b want %b", outs, RUN);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= T; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
         checks++;
         if (outs !== FROZEN || mem_err_o !== 1'b0) begin
            errors++; $display("FAIL timeout_cycle%0d: got %b err %b want %b err 0", i, outs, mem_err_o, FROZEN);
         end
      end
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         checks++;
         if (outs !== RUN || mem_err_o !== 1'b1) begin
            errors++; $display("FAIL timeout_after%0d: got %b err %b want %b err 1", i, outs, mem_err_o, RUN);
         end
      end
   endtask

   // Runs straight after test_timeout so mem_err_o is 1 going in.
   task automatic test_async_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      #1;
      checks++;
      if (outs !== RUN || mem_err_o !== 1'b0) begin
         errors++; $display("FAIL async_reset: got %b err %b want %b err 0", outs, mem_err_o, RUN);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (bubble_cnt_o !== 32'd0 || freeze_cnt_o !== 32'd0) begin
         errors++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", bubble_cnt_o, freeze_cnt_o);
      end
`endif
      @(negedge clk_i);
      EXMEM_MemAccess_i = 1'b0;
      rst_i = 1'b1;
      idle_inputs();
      checks++;
      if (outs !== RUN) begin
         errors++; $display("FAIL post_reset: got %b want %b", outs, RUN);
      end
   endtask

   // Reference: a freeze lasts from an unacked access until the ack (not the
   // first cycle) or until T frozen cycles have elapsed, which sets the error.
   task automatic test_random();
      int run;
      bit err;
      int bub_n;
      int frz_n;
      logic [4:0] rs, rt, idrt;
      logic rsu, rtu, mr, acc, ack;
      bit lu, frz, flush;
      logic [3:0] exp;
      run = 0; err = 0; bub_n = 0; frz_n = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rs   = 5'($urandom_range(0, 3));
         rt   = 5'($urandom_range(0, 3));
         idrt = 5'($urandom_range(0, 3));
         rsu  = 1'($urandom_range(0, 1));
         rtu  = 1'($urandom_range(0, 1));
         mr   = 1'($urandom_range(0, 1));
         acc  = (run > 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
         ack  = 1'($urandom_range(0, 4) == 0);
         drive(rs, rt, rsu, rtu, mr, idrt, acc, ack);

         lu    = mr && idrt != 0 && ((rsu && idrt == rs) || (rtu && idrt == rt));
         frz   = (run > 0) || (acc && !ack);
         flush = !frz && lu;
         exp   = {!frz && !lu, !frz && !lu, flush, frz};

         checks++;
         if (outs !== exp || mem_err_o !== err) begin
            errors++;
            $display("FAIL random_c%0d: got %b err %b want %b err %b", c, outs, mem_err_o, exp, err);
         end
`ifdef HAZARD_PERF_EN
         checks++;
         if (bubble_cnt_o !== 32'(bub_n) || freeze_cnt_o !== 32'(frz_n)) begin
            errors++;
            $display("FAIL random_cnt_c%0d: got %0d/%0d want %0d/%0d", c, bubble_cnt_o, freeze_cnt_o, bub_n, frz_n);
         end
`endif
         if (flush) bub_n++;
         if (frz) begin
            frz_n++;
            if (run > 0 && ack) run = 0;
            else if (run + 1 == T) begin run = 0; err = 1; end
            else run = run + 1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_mem_wait();
      test_freeze_vs_load_use();
      test_timeout();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
